mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter that lets the pipelined MIPS core run against a single unified instruction/data memory. The fetch-side requester (PC/instruction port) and the memory-stage requester (data load/store port) each hold a request until they receive a one-cycle `valid` pulse; the core stalls the relevant stage while the request is outstanding. A three-state FSM serialises accesses onto a req/ack memory bus. Data accesses have priority, with a bounded starvation guard for instruction fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive data grants allowed while fetch waits (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `if_req`  in  1  fetch request, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_rdata`  out  DATA_W  fetched word, registered
- `if_valid`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request, held until `d_valid`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, registered
- `d_valid`  out  1  one-cycle completion pulse for data
- `mem_req`  out  1  bus request, held until `mem_ack`
- `mem_we`  out  1  bus write enable
- `mem_addr`  out  ADDR_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_rdata`  in  DATA_W  bus read data, valid with `mem_ack`
- `mem_ack`  in  1  bus completion, one cycle

## Operation
- FSM states are IDLE, BUSY and RESP.
- **IDLE:** arbitrate among requesters sampled high.
  - Only one pending: grant it.
  - Both pending: grant data, unless `starve_cnt == STARVE_LIMIT`, then grant fetch.
  - On a grant, latch `mem_addr`/`mem_we`/`mem_wdata` and grant owner, set `mem_req`=1, and go to BUSY.
  - Fetch grants drive `mem_we`=0.
- **BUSY:** hold all `mem_*` outputs stable.
  - On `mem_ack`, capture `mem_rdata` into the owner's rdata register, drop `mem_req`, and go to RESP.
  - A data write does not update `d_rdata`.
- **RESP:** assert the owner's `valid` for exactly one cycle, then go to IDLE.
  - Requests are not sampled in RESP. This prevents re-serving a request the owner has not yet dropped.
- **starve_cnt:**
  - Increments on each data grant made while `if_req`=1.
  - Clears on a fetch grant, and in IDLE when `if_req`=0.
  - Saturates at `STARVE_LIMIT`.
- `mem_ack` outside BUSY is ignored.
- `if_valid` and `d_valid` are never high in the same cycle.
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_valid`, `d_valid` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; `starve_cnt` = 0.
- Reset mid-transaction abandons the access with no `valid` pulse. The memory shares `rst` and drops its own state.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request sampled in IDLE at cycle 0 → `mem_req`=1 from cycle 1.
- `mem_ack` at cycle k (k ≥ 1) → `valid` and rdata at k+1 → IDLE at k+2.
- Minimum request-to-valid latency is 2 cycles. Peak throughput is one access per 3 cycles.
- The requester deasserts or changes `req` on the edge ending its `valid` cycle. The value seen at k+2 is treated as a new request.
- A request arriving during BUSY/RESP waits. Arbitration uses only values sampled in IDLE.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t`
  - `typedef enum logic {GNT_IF, GNT_D} arb_owner_t`
- Single module; no sub-module. Priority, starvation counter and FSM are small enough to stay inline.
- The starvation counter width is `$clog2(STARVE_LIMIT+1)`.

## Test plan
- Fetch only, `if_addr`=0x0000_0040, `mem_ack` in the first BUSY cycle, `mem_rdata`=0x2008_0005 → `mem_req` at cycle 1, `if_valid` and `if_rdata`=0x2008_0005 at cycle 2, `mem_req`=0 at cycle 2.
- Fetch and data load both asserted in the same IDLE cycle → data granted first. Then fetch is granted: `d_valid` precedes `if_valid` by 3 cycles with 1-cycle ack.
- Store `d_addr`=0x54, `d_wdata`=0xDEAD_BEEF, ack after 3 BUSY cycles → `mem_we`=1 and address/data stable for all 3 cycles, `d_valid` pulses, `d_rdata` unchanged.
- `if_req` held high while `d_req` re-requests back-to-back, `STARVE_LIMIT`=4 → exactly 4 data grants, then a fetch grant, then the count restarts.
- `rst` asserted in BUSY → `mem_req`=0 immediately (async), no `valid` pulse. After release, a pending `if_req` is granted normally.
- Spurious `mem_ack` in IDLE and RESP → no state change, no `valid`, no rdata update.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic {GNT_IF, GNT_D} arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-stage requests onto one req/ack memory bus.
// Data wins ties unless fetch has already waited STARVE_LIMIT data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_owner_t       owner;
    logic [CNT_W-1:0] starveCnt;
    logic             grantData;
    logic             grantFetch;

    // Arbitration decision; only acted upon while idle.
    always_comb begin
        grantData  = d_req && (!if_req || (starveCnt != CNT_MAX));
        grantFetch = if_req && !grantData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            owner     <= GNT_IF;
            starveCnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (!if_req) begin
                        starveCnt <= '0;
                    end
                    if (grantData) begin
                        owner     <= GNT_D;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_req   <= 1'b1;
                        state     <= ARB_BUSY;
                        if (if_req && (starveCnt != CNT_MAX)) begin
                            starveCnt <= starveCnt + CNT_W'(1);
                        end
                    end else if (grantFetch) begin
                        owner     <= GNT_IF;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_req   <= 1'b1;
                        starveCnt <= '0;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ARB_RESP;
                        if (owner == GNT_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            // Stores complete without touching the load register.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_valid <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-built corner sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isData;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackDelay;
        logic [31:0] busRdata;
        logic [31:0] expRdata;
    } txn_t;

    txn_t        vec [5];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expIfRdata = '0;
    logic [31:0] expDRdata  = '0;
    logic        expFetch;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue one request from an idle arbiter and follow it to completion.
    task automatic runTxn(input txn_t v, input int idx);
        if_req  = !v.isData;
        d_req   = v.isData;
        d_we    = v.we;
        if_addr = v.addr;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        tick();
        for (int c = 1; c <= v.ackDelay; c++) begin
            check($sformatf("v%0d_busy%0d_req", idx, c), mem_req, 1);
            check($sformatf("v%0d_busy%0d_we", idx, c), mem_we, v.we);
            check($sformatf("v%0d_busy%0d_addr", idx, c), mem_addr, v.addr);
            if (v.we) check($sformatf("v%0d_busy%0d_wdata", idx, c), mem_wdata, v.wdata);
            check($sformatf("v%0d_busy%0d_valid", idx, c), {if_valid, d_valid}, 2'b00);
            if (c == v.ackDelay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.busRdata;
            end
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_0000;
        if (v.isData) expDRdata = v.expRdata;
        else          expIfRdata = v.expRdata;
        check($sformatf("v%0d_resp_req", idx), mem_req, 0);
        check($sformatf("v%0d_resp_if_valid", idx), if_valid, !v.isData);
        check($sformatf("v%0d_resp_d_valid", idx), d_valid, v.isData);
        check($sformatf("v%0d_resp_if_rdata", idx), if_rdata, expIfRdata);
        check($sformatf("v%0d_resp_d_rdata", idx), d_rdata, expDRdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        check($sformatf("v%0d_idle_valid", idx), {if_valid, d_valid}, 2'b00);
        $display("txn %0d: %s addr=%08h ack_after=%0d if_rdata=%08h d_rdata=%08h",
                 idx, v.isData ? (v.we ? "store" : "load ") : "fetch", v.addr, v.ackDelay,
                 if_rdata, d_rdata);
    endtask

    initial begin
        vec[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h2008_0005, 32'h2008_0005};
        vec[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, 32'h1234_5678};
        vec[2] = '{1'b1, 1'b1, 32'h0000_0054, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 32'h1234_5678};
        vec[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h8C09_0000, 32'h8C09_0000};
        vec[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4, 32'hCAFE_F00D, 32'hCAFE_F00D};

        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_valids", {if_valid, d_valid}, 2'b00);
        check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) runTxn(vec[i], i);

        // Simultaneous fetch and load: data first, fetch follows three cycles later.
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        check("both_first_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0011;
        tick();
        mem_ack = 1'b0;
        check("both_d_valid", {if_valid, d_valid}, 2'b01);
        check("both_d_rdata", d_rdata, 32'h11);
        d_req = 1'b0;
        tick();
        check("both_idle_valid", {if_valid, d_valid}, 2'b00);
        tick();
        check("both_second_addr", mem_addr, 32'h80);
        check("both_second_we", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
        tick();
        mem_ack = 1'b0;
        check("both_if_valid", {if_valid, d_valid}, 2'b10);
        check("both_if_rdata", if_rdata, 32'h22);
        if_req = 1'b0;
        tick();
        expIfRdata = 32'h22; expDRdata = 32'h11;
        $display("txn both: data then fetch done");

        // Fetch held while data re-requests: pattern D D D D I repeating.
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int g = 0; g < 10; g++) begin
            expFetch = (g % 5 == 4);
            tick();
            check($sformatf("starve_g%0d_addr", g), mem_addr,
                  expFetch ? 32'h80 : 32'h300 + 32'(g * 4));
            mem_ack = 1'b1; mem_rdata = 32'(g);
            tick();
            mem_ack = 1'b0;
            check($sformatf("starve_g%0d_valid", g), {if_valid, d_valid},
                  expFetch ? 2'b10 : 2'b01);
            if (expFetch) expIfRdata = 32'(g);
            else          expDRdata  = 32'(g);
            d_addr = 32'h300 + 32'((g + 1) * 4);
            tick();
            $display("txn starve %0d: owner=%s addr=%08h", g, expFetch ? "fetch" : "data", mem_addr);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        check("starve_end_rdata", {if_rdata, d_rdata}, {expIfRdata, expDRdata});

        // Asynchronous reset while the bus access is outstanding.
        if_req = 1'b1; if_addr = 32'h90;
        tick();
        check("rst_busy_req", mem_req, 1);
        #2 rst = 1'b0;
        #1 check("rst_async_req", mem_req, 0);
        check("rst_async_valid", {if_valid, d_valid}, 2'b00);
        tick();
        check("rst_hold_valid", {if_valid, d_valid}, 2'b00);
        expIfRdata = '0; expDRdata = '0;
        check("rst_rdata_cleared", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b1;
        tick();
        check("rst_regrant_req", mem_req, 1);
        check("rst_regrant_addr", mem_addr, 32'h90);
        mem_ack = 1'b1; mem_rdata = 32'h1234_ABCD;
        tick();
        mem_ack = 1'b0;
        check("rst_regrant_valid", {if_valid, d_valid}, 2'b10);
        check("rst_regrant_rdata", if_rdata, 32'h1234_ABCD);
        expIfRdata = 32'h1234_ABCD;
        if_req = 1'b0;
        tick();
        $display("txn reset: abandoned access, regrant fetch done");

        // Stray acks with no bus access in flight.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        check("spur_idle_req", mem_req, 0);
        check("spur_idle_valid", {if_valid, d_valid}, 2'b00);
        check("spur_idle_rdata", {if_rdata, d_rdata}, {expIfRdata, expDRdata});
        mem_ack = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        check("spur_load_valid", {if_valid, d_valid}, 2'b01);
        check("spur_load_rdata", d_rdata, 32'h55);
        d_req = 1'b0; mem_rdata = 32'h0000_0066;
        tick();
        check("spur_resp_valid", {if_valid, d_valid}, 2'b00);
        check("spur_resp_rdata", d_rdata, 32'h55);
        check("spur_resp_req", mem_req, 0);
        mem_ack = 1'b0;
        tick();
        check("spur_after_req", mem_req, 0);
        $display("txn spurious: acks in IDLE and RESP ignored");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
